// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC sequencer for the accumulator processor.
// Converts raw decoder flags into single-cycle datapath strobes and includes a memory-wait watchdog.
module instr_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             mem_ready,
  input  logic             ctl_regwr,
  input  logic             ctl_accwr,
  input  logic             ctl_memrd,
  input  logic             ctl_memwr,
  input  logic             ctl_halt,
  input  logic             ctl_branch,
  input  logic             ctl_lookup,
  input  logic             branch_cond,
  output logic             pc_clear,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ir_load,
  output logic             reg_we,
  output logic             acc_we,
  output logic             lut_en,
  output logic             mem_re,
  output logic             mem_we,
  output logic             busy,
  output logic             Done,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [4:0]       WAIT_LAST = 5'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [4:0]       wait_reg, wait_next;
  logic             mem_err_reg, mem_err_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // Decoder flags captured at the end of DECODE; halt needs no copy since it exits immediately.
  logic flag_regwr_reg, flag_accwr_reg, flag_memrd_reg;
  logic flag_memwr_reg, flag_branch_reg, flag_lookup_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= S_IDLE;
      wait_reg    <= '0;
      mem_err_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      mem_err_reg <= mem_err_next;
      count_reg   <= count_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      flag_regwr_reg  <= 1'b0;
      flag_accwr_reg  <= 1'b0;
      flag_memrd_reg  <= 1'b0;
      flag_memwr_reg  <= 1'b0;
      flag_branch_reg <= 1'b0;
      flag_lookup_reg <= 1'b0;
    end else if (state_reg == S_DECODE) begin
      flag_regwr_reg  <= ctl_regwr;
      flag_accwr_reg  <= ctl_accwr;
      flag_memrd_reg  <= ctl_memrd;
      flag_memwr_reg  <= ctl_memwr;
      flag_branch_reg <= ctl_branch;
      flag_lookup_reg <= ctl_lookup;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    mem_err_next = mem_err_reg;
    count_next   = count_reg;
    pc_clear     = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ir_load      = 1'b0;
    reg_we       = 1'b0;
    acc_we       = 1'b0;
    lut_en       = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    busy         = 1'b0;
    Done         = 1'b0;

    case (state_reg)
      S_IDLE, S_HALTED: begin
        Done = (state_reg == S_HALTED);
        // pc_clear is combinational on Start, so it must stay low while reset is held.
        if (Start && Reset) begin
          pc_clear     = 1'b1;
          count_next   = '0;
          mem_err_next = 1'b0;
          state_next   = S_FETCH;
        end
      end

      S_FETCH: begin
        busy       = 1'b1;
        ir_load    = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        busy = 1'b1;
        if (ctl_halt) begin
          state_next = S_HALTED;
        end else if (ctl_memrd || ctl_memwr) begin
          wait_next  = '0;
          state_next = S_MEM;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_MEM: begin
        busy   = 1'b1;
        mem_we = flag_memwr_reg;
        mem_re = flag_memrd_reg && !flag_memwr_reg;
        if (mem_ready) begin
          state_next = S_EXEC;
        end else if (wait_reg == WAIT_LAST) begin
          mem_err_next = 1'b1;
          state_next   = S_HALTED;
        end else begin
          wait_next = wait_reg + 5'd1;
        end
      end

      S_EXEC: begin
        busy    = 1'b1;
        reg_we  = flag_regwr_reg;
        acc_we  = flag_accwr_reg;
        lut_en  = flag_lookup_reg;
        pc_load = flag_branch_reg && branch_cond;
        pc_inc  = !(flag_branch_reg && branch_cond);
        if (count_reg != CNT_MAX) begin
          count_next = count_reg + CNT_W'(1);
        end
        state_next = S_FETCH;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign mem_err     = mem_err_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a decoder model feeds directed programs, and a monitor compares each active output cycle against a queue of expected records.
module tb_instr_sequencer;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
  logic mem_ready = 1'b0;
  logic ctl_regwr = 1'b0, ctl_accwr = 1'b0, ctl_memrd = 1'b0, ctl_memwr = 1'b0;
  logic ctl_halt = 1'b0, ctl_branch = 1'b0, ctl_lookup = 1'b0, branch_cond = 1'b0;

  logic pc_clear, pc_inc, pc_load, ir_load, reg_we, acc_we, lut_en;
  logic mem_re, mem_we, busy, Done, mem_err;
  logic [15:0] instr_count;

  logic pc_clear_b, pc_inc_b, pc_load_b, ir_load_b, reg_we_b, acc_we_b, lut_en_b;
  logic mem_re_b, mem_we_b, busy_b, done_b, mem_err_b;
  logic [1:0] instr_count_b;

  instr_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .mem_ready(mem_ready),
    .ctl_regwr(ctl_regwr), .ctl_accwr(ctl_accwr), .ctl_memrd(ctl_memrd),
    .ctl_memwr(ctl_memwr), .ctl_halt(ctl_halt), .ctl_branch(ctl_branch),
    .ctl_lookup(ctl_lookup), .branch_cond(branch_cond),
    .pc_clear(pc_clear), .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load),
    .reg_we(reg_we), .acc_we(acc_we), .lut_en(lut_en), .mem_re(mem_re),
    .mem_we(mem_we), .busy(busy), .Done(Done), .mem_err(mem_err),
    .instr_count(instr_count)
  );

  // Narrow-counter copy, used only to observe saturation.
  instr_sequencer #(.CNT_W(2), .MEM_TIMEOUT(15)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Start(Start), .mem_ready(mem_ready),
    .ctl_regwr(ctl_regwr), .ctl_accwr(ctl_accwr), .ctl_memrd(ctl_memrd),
    .ctl_memwr(ctl_memwr), .ctl_halt(ctl_halt), .ctl_branch(ctl_branch),
    .ctl_lookup(ctl_lookup), .branch_cond(branch_cond),
    .pc_clear(pc_clear_b), .pc_inc(pc_inc_b), .pc_load(pc_load_b), .ir_load(ir_load_b),
    .reg_we(reg_we_b), .acc_we(acc_we_b), .lut_en(lut_en_b), .mem_re(mem_re_b),
    .mem_we(mem_we_b), .busy(busy_b), .Done(done_b), .mem_err(mem_err_b),
    .instr_count(instr_count_b)
  );

  always #5 Clk = ~Clk;

  // Vector order: pc_clear pc_inc pc_load ir_load reg_we acc_we lut_en mem_re mem_we busy Done
  localparam logic [10:0] V_CLR  = 11'b100_0000_0000;
  localparam logic [10:0] V_CLRD = 11'b100_0000_0001;
  localparam logic [10:0] V_F    = 11'b000_1000_0010;
  localparam logic [10:0] V_D    = 11'b000_0000_0010;
  localparam logic [10:0] V_MR   = 11'b000_0000_1010;
  localparam logic [10:0] V_MW   = 11'b000_0000_0110;
  localparam logic [10:0] V_EACC = 11'b010_0010_0010;
  localparam logic [10:0] V_EREG = 11'b010_0100_0010;
  localparam logic [10:0] V_ELUT = 11'b010_0001_0010;
  localparam logic [10:0] V_EBR  = 11'b001_0000_0010;
  localparam logic [10:0] V_EINC = 11'b010_0000_0010;
  localparam logic [10:0] V_H    = 11'b000_0000_0001;

  typedef struct {
    bit rw, aw, mr, mw, h, br, lu, cd;
    int rdy;
  } instr_t;

  typedef struct {
    logic [10:0] vec;
    logic        err;
    bit          chk_cnt;
    int          cnt;
    int          cnt2;
  } exp_t;

  instr_t prog_q[$];
  exp_t   exp_q[$];
  instr_t cur_i;
  exp_t   mon_e;
  logic [10:0] mon_vec;
  int checks = 0;
  int fails  = 0;
  int rdy_cur = -1;
  int mcnt = 0;
  int rec_no = 0;
  logic done_d = 1'b0;

  function automatic instr_t ins(input bit rw, aw, mr, mw, h, br, lu, cd, input int rdy);
    instr_t i;
    i.rw = rw; i.aw = aw; i.mr = mr; i.mw = mw;
    i.h = h; i.br = br; i.lu = lu; i.cd = cd; i.rdy = rdy;
    return i;
  endfunction

  task automatic ex(input logic [10:0] v, input logic e);
    exp_t x;
    x.vec = v; x.err = e; x.chk_cnt = 1'b0; x.cnt = 0; x.cnt2 = 0;
    exp_q.push_back(x);
  endtask

  task automatic exh(input logic e, input int c, input int c2);
    exp_t x;
    x.vec = V_H; x.err = e; x.chk_cnt = 1'b1; x.cnt = c; x.cnt2 = c2;
    exp_q.push_back(x);
  endtask

  task automatic ex_instr(input logic [10:0] exec_vec);
    ex(V_F, 1'b0);
    ex(V_D, 1'b0);
    ex(exec_vec, 1'b0);
  endtask

  task automatic launch();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!Done && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!Done) begin
      checks++; fails++;
      $display("FAIL %s done_timeout got Done=%b required Done=1 within 100 cycles", tag, Done);
    end
  endtask

  // Decoder/memory model: supplies flags in FETCH and answers memory requests after rdy wait cycles.
  always @(posedge Clk) begin
    #1;
    if (ir_load && prog_q.size() > 0) begin
      cur_i = prog_q.pop_front();
      ctl_regwr = cur_i.rw; ctl_accwr = cur_i.aw; ctl_memrd = cur_i.mr;
      ctl_memwr = cur_i.mw; ctl_halt = cur_i.h; ctl_branch = cur_i.br;
      ctl_lookup = cur_i.lu; branch_cond = cur_i.cd; rdy_cur = cur_i.rdy;
    end
    if (mem_re || mem_we) begin
      mem_ready = (rdy_cur >= 0 && mcnt == rdy_cur);
      mcnt++;
    end else begin
      mem_ready = 1'b0;
      mcnt = 0;
    end
  end

  // Monitor: every active cycle (busy, pc_clear, or Done rising) pops one expected record.
  always @(negedge Clk) begin
    mon_vec = {pc_clear, pc_inc, pc_load, ir_load, reg_we, acc_we, lut_en,
               mem_re, mem_we, busy, Done};
    if (Reset && (busy || pc_clear || (Done && !done_d))) begin
      rec_no++;
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_output rec %0d got=%b required=none", rec_no, mon_vec);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (mon_vec !== mon_e.vec) begin
          fails++;
          $display("FAIL strobes rec %0d got=%b required=%b", rec_no, mon_vec, mon_e.vec);
        end
        checks++;
        if (mem_err !== mon_e.err) begin
          fails++;
          $display("FAIL mem_err rec %0d got=%b required=%b", rec_no, mem_err, mon_e.err);
        end
        if (mon_e.chk_cnt) begin
          checks++;
          if (instr_count !== 16'(mon_e.cnt)) begin
            fails++;
            $display("FAIL instr_count rec %0d got=%0d required=%0d", rec_no, instr_count, mon_e.cnt);
          end
          checks++;
          if (instr_count_b !== 2'(mon_e.cnt2)) begin
            fails++;
            $display("FAIL sat_count rec %0d got=%0d required=%0d", rec_no, instr_count_b, mon_e.cnt2);
          end
          $display("rec %0d halt: vec=%b mem_err=%b count=%0d sat_count=%0d",
                   rec_no, mon_vec, mem_err, instr_count, instr_count_b);
        end else begin
          $display("rec %0d: vec=%b", rec_no, mon_vec);
        end
      end
    end
    done_d <= Done;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge Clk);
    checks++;
    if ({pc_clear, pc_inc, pc_load, ir_load, reg_we, acc_we, lut_en, mem_re, mem_we,
         busy, Done, mem_err} !== 12'b0 || instr_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_state got outs=%b count=%0d required all 0",
               {pc_clear, pc_inc, pc_load, ir_load, reg_we, acc_we, lut_en, mem_re,
                mem_we, busy, Done, mem_err}, instr_count);
    end
    @(posedge Clk); #1 Reset = 1'b1;

    // 1: reset asserted in the second MEM cycle of a store
    ex(V_CLR, 1'b0); ex(V_F, 1'b0); ex(V_D, 1'b0); ex(V_MW, 1'b0);
    prog_q.push_back(ins(0, 0, 0, 1, 0, 0, 0, 0, -1));
    launch();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if ({pc_clear, pc_inc, pc_load, ir_load, reg_we, acc_we, lut_en, mem_re, mem_we,
         busy, Done, mem_err} !== 12'b0 || instr_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_mem got outs=%b count=%0d required all 0",
               {pc_clear, pc_inc, pc_load, ir_load, reg_we, acc_we, lut_en, mem_re,
                mem_we, busy, Done, mem_err}, instr_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pre_reset_records got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge Clk); #1 Reset = 1'b1;
    ex(V_CLR, 1'b0); ex(V_F, 1'b0); ex(V_D, 1'b0); exh(1'b0, 0, 0);
    prog_q.push_back(ins(0, 0, 0, 0, 1, 0, 0, 0, -1));
    launch();
    wait_done("t1");

    // 2: three accumulator ops then halt
    ex(V_CLRD, 1'b0);
    repeat (3) ex_instr(V_EACC);
    ex(V_F, 1'b0); ex(V_D, 1'b0); exh(1'b0, 3, 3);
    repeat (3) prog_q.push_back(ins(0, 1, 0, 0, 0, 0, 0, 0, -1));
    prog_q.push_back(ins(0, 0, 0, 0, 1, 0, 0, 0, -1));
    launch();
    wait_done("t2");

    // 3: load with two wait cycles, then read+write+lookup (write wins, ready at once)
    ex(V_CLRD, 1'b0); ex(V_F, 1'b0); ex(V_D, 1'b0);
    repeat (3) ex(V_MR, 1'b0);
    ex(V_EREG, 1'b0);
    ex(V_F, 1'b0); ex(V_D, 1'b0); ex(V_MW, 1'b0); ex(V_ELUT, 1'b0);
    ex(V_F, 1'b0); ex(V_D, 1'b0); exh(1'b0, 2, 2);
    prog_q.push_back(ins(1, 0, 1, 0, 0, 0, 0, 0, 2));
    prog_q.push_back(ins(0, 0, 1, 1, 0, 0, 1, 0, 0));
    prog_q.push_back(ins(0, 0, 0, 0, 1, 0, 0, 0, -1));
    launch();
    wait_done("t3");

    // 4: branch taken, then branch not taken
    ex(V_CLRD, 1'b0);
    ex_instr(V_EBR);
    ex_instr(V_EINC);
    ex(V_F, 1'b0); ex(V_D, 1'b0); exh(1'b0, 2, 2);
    prog_q.push_back(ins(0, 0, 0, 0, 0, 1, 0, 1, -1));
    prog_q.push_back(ins(0, 0, 0, 0, 0, 1, 0, 0, -1));
    prog_q.push_back(ins(0, 0, 0, 0, 1, 0, 0, 0, -1));
    launch();
    wait_done("t4");

    // 5: store never acknowledged -> watchdog after 15 MEM cycles; relaunch clears mem_err
    ex(V_CLRD, 1'b0); ex(V_F, 1'b0); ex(V_D, 1'b0);
    repeat (15) ex(V_MW, 1'b0);
    exh(1'b1, 0, 0);
    prog_q.push_back(ins(0, 0, 0, 1, 0, 0, 0, 0, -1));
    launch();
    wait_done("t5a");
    ex(V_CLRD, 1'b1); ex(V_F, 1'b0); ex(V_D, 1'b0); exh(1'b0, 0, 0);
    prog_q.push_back(ins(0, 0, 0, 0, 1, 0, 0, 0, -1));
    launch();
    wait_done("t5b");

    // 6: Start pulsed during EXEC is ignored; five ops saturate the 2-bit counter at 3
    ex(V_CLRD, 1'b0);
    repeat (5) ex_instr(V_EACC);
    ex(V_F, 1'b0); ex(V_D, 1'b0); exh(1'b0, 5, 3);
    repeat (5) prog_q.push_back(ins(0, 1, 0, 0, 0, 0, 0, 0, -1));
    prog_q.push_back(ins(0, 0, 0, 0, 1, 0, 0, 0, -1));
    launch();
    repeat (5) @(posedge Clk);
    #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    wait_done("t6");

    repeat (2) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_records got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
